// File: rtl/usr_pkg.sv
// Shared mode encodings for shift-type register blocks.
// Also provides helpers that classify modes for counting.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD  = 3'b000,
        USR_SHR   = 3'b001,
        USR_SHL   = 3'b010,
        USR_ROR   = 3'b011,
        USR_ROL   = 3'b100,
        USR_LOAD  = 3'b101,
        USR_ASR   = 3'b110,
        USR_CLEAR = 3'b111
    } usr_mode_e;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == USR_SHR) || (m == USR_SHL) || (m == USR_ROR) ||
               (m == USR_ROL) || (m == USR_ASR);
    endfunction

    function automatic logic is_reload(input logic [2:0] m);
        return (m == USR_LOAD) || (m == USR_CLEAR);
    endfunction

endpackage

// File: rtl/usr_word_counter.sv
// Counts shift operations within a word and pulses word_done
// for one cycle when WIDTH shifts have completed.
module usr_word_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic clr,
    output logic word_done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          done_d, done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (step) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign word_done = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shifts, rotates, arithmetic shift,
// parallel load and clear, with a per-word completion pulse.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             word_done
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             step;
    logic             clr;

    // Unknown or undefined modes fall through to hold.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                USR_SHR:   q_d = {sin_msb, q_q[WIDTH-1:1]};
                USR_SHL:   q_d = {q_q[WIDTH-2:0], sin_lsb};
                USR_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                USR_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                USR_LOAD:  q_d = pin;
                USR_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                USR_CLEAR: q_d = '0;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign step = en & is_shift(mode);
    assign clr  = en & is_reload(mode);

    usr_word_counter #(
        .WIDTH(WIDTH)
    ) u_word_counter (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .clr       (clr),
        .word_done (word_done)
    );

    assign q        = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH=4.
// Expected values are hand-computed per vector.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_msb = 1'b0;
    logic       sin_lsb = 1'b0;
    logic [3:0] pin = 4'h0;
    logic [3:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic       word_done;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] SHR   = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] ROL   = 3'b100;
    localparam logic [2:0] LOAD  = 3'b101;
    localparam logic [2:0] ASR   = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .sin_msb   (sin_msb),
        .sin_lsb   (sin_lsb),
        .pin       (pin),
        .q         (q),
        .sout_lsb  (sout_lsb),
        .sout_msb  (sout_msb),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic e, input logic [2:0] m,
                      input logic smsb, input logic slsb,
                      input logic [3:0] p);
        en = e;
        mode = m;
        sin_msb = smsb;
        sin_lsb = slsb;
        pin = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        check("rst_q", q, 4'h0);
        check("rst_done", word_done, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;

        // shift right, serial out at lsb
        op(1, LOAD, 0, 0, 4'b1011);
        check("shr_load_q", q, 4'b1011);
        check("shr_sout0", sout_lsb, 1'b1);
        check("shr_msb0", sout_msb, 1'b1);
        op(1, SHR, 0, 0, 0);
        check("shr_sout1", sout_lsb, 1'b1);
        check("shr_done1", word_done, 1'b0);
        op(1, SHR, 0, 0, 0);
        check("shr_sout2", sout_lsb, 1'b0);
        op(1, SHR, 0, 0, 0);
        check("shr_sout3", sout_lsb, 1'b1);
        check("shr_done3", word_done, 1'b0);
        op(1, SHR, 0, 0, 0);
        check("shr_q4", q, 4'b0000);
        check("shr_done4", word_done, 1'b1);
        op(1, HOLD, 0, 0, 0);
        check("shr_done_drop", word_done, 1'b0);
        check("hold_q", q, 4'b0000);

        // rotate left
        op(1, LOAD, 0, 0, 4'b1001);
        op(1, ROL, 0, 0, 0);
        check("rol_q1", q, 4'b0011);
        op(1, ROL, 0, 0, 0);
        check("rol_q2", q, 4'b0110);
        op(1, ROL, 0, 0, 0);
        check("rol_q3", q, 4'b1100);
        check("rol_done3", word_done, 1'b0);
        op(1, ROL, 0, 0, 0);
        check("rol_q4", q, 4'b1001);
        check("rol_done4", word_done, 1'b1);

        // arithmetic shift and shift left from clear
        op(1, LOAD, 0, 0, 4'b1000);
        check("asr_done_clr", word_done, 1'b0);
        op(1, ASR, 0, 0, 0);
        check("asr_q1", q, 4'b1100);
        op(1, ASR, 0, 0, 0);
        check("asr_q2", q, 4'b1110);
        op(1, CLEAR, 0, 0, 0);
        check("clr_q", q, 4'b0000);
        op(1, SHL, 0, 1, 0);
        check("shl_q1", q, 4'b0001);
        op(1, SHL, 0, 1, 0);
        check("shl_q2", q, 4'b0011);

        // reload restarts the word count
        op(1, LOAD, 0, 0, 4'b0110);
        op(1, SHL, 0, 0, 0);
        op(1, SHL, 0, 0, 0);
        check("rl_q2", q, 4'b1000);
        op(1, LOAD, 0, 0, 4'b1111);
        op(1, SHL, 0, 0, 0);
        op(1, SHL, 0, 0, 0);
        check("rl_done2", word_done, 1'b0);
        op(1, SHL, 0, 0, 0);
        check("rl_done3", word_done, 1'b0);
        check("rl_q3", q, 4'b1000);
        op(1, SHL, 0, 0, 0);
        check("rl_done4", word_done, 1'b1);
        check("rl_q4", q, 4'b0000);

        // en=0 mid-word stalls the count
        op(1, LOAD, 0, 0, 4'b1010);
        op(1, SHL, 0, 0, 0);
        op(1, SHL, 0, 0, 0);
        op(0, SHL, 0, 1, 0);
        check("en0_q", q, 4'b1000);
        check("en0_done1", word_done, 1'b0);
        op(0, LOAD, 0, 0, 4'b0101);
        check("en0_q_load", q, 4'b1000);
        op(1, SHL, 0, 0, 0);
        check("en0_done3", word_done, 1'b0);
        op(1, SHL, 0, 0, 0);
        check("en0_done4", word_done, 1'b1);
        op(0, SHL, 0, 0, 0);
        check("en0_done_drop", word_done, 1'b0);

        // async reset mid-word
        op(1, LOAD, 0, 0, 4'b1011);
        op(1, SHR, 0, 0, 0);
        op(1, SHR, 0, 0, 0);
        check("ar_q2", q, 4'b0010);
        #3 reset = 1'b0;
        #1;
        check("ar_q", q, 4'b0000);
        check("ar_done", word_done, 1'b0);
        en = 1'b1;
        mode = SHR;
        @(posedge clk);
        #1;
        check("ar_q_hold", q, 4'b0000);
        reset = 1'b1;
        op(1, LOAD, 0, 0, 4'b1111);
        op(1, SHR, 1, 0, 0);
        op(1, SHR, 0, 0, 0);
        op(1, SHR, 0, 0, 0);
        check("ar_done3", word_done, 1'b0);
        check("ar_q3", q, 4'b0011);
        op(1, SHR, 0, 0, 0);
        check("ar_done4", word_done, 1'b1);
        check("ar_q4", q, 4'b0001);

        // reset alone, then count from zero without a load
        #3 reset = 1'b0;
        #3 reset = 1'b1;
        op(1, SHL, 0, 1, 0);
        op(1, SHL, 0, 1, 0);
        op(1, SHL, 0, 1, 0);
        check("rz_done3", word_done, 1'b0);
        op(1, SHL, 0, 1, 0);
        check("rz_done4", word_done, 1'b1);
        check("rz_q4", q, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
